// File: rtl/face_box_locator.sv
`default_nettype none
// ============================================================================
// Module   : face_box_locator
// Function : Scans a captured binary image row-wise, then column-wise, and
//            reports the bounding box of the bright region.
// Revision : 1.0 - initial release
// ============================================================================
module face_box_locator #(
   parameter int ROWS       = 150,
   parameter int COLS       = 300,
   parameter int ROW_THRESH = 20,
   parameter int COL_THRESH = 10
) (
   input  logic                      pixclk,
   input  logic                      RESET,
   input  logic                      dataready,
   input  logic [0:ROWS-1][0:COLS-1] image,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [7:0]                top,
   output logic [7:0]                bottom,
   output logic [8:0]                left,
   output logic [8:0]                right
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ROWSCAN = 2'd1,
      S_COLSCAN = 2'd2,
      S_DONE    = 2'd3
   } t_state;

   t_state          r_state;
   t_state          w_state_nxt;

   logic [8:0]      r_idx;
   logic            r_rowhit;
   logic            r_colhit;
   logic [7:0]      r_top_c;
   logic [7:0]      r_bot_c;
   logic [8:0]      r_left_c;
   logic [8:0]      r_right_c;

   logic            r_found;
   logic [7:0]      r_top;
   logic [7:0]      r_bottom;
   logic [8:0]      r_left;
   logic [8:0]      r_right;

   logic [7:0]      w_row_idx;
   logic [0:COLS-1] w_row;
   logic [0:ROWS-1] w_col;
   logic [8:0]      w_rc;
   logic [7:0]      w_cc;
   logic            w_row_hit;
   logic            w_col_hit;
   logic            w_row_last;
   logic            w_col_last;
   logic            w_colhit_nxt;
   logic [8:0]      w_left_nxt;
   logic [8:0]      w_right_nxt;

   // Row index is only meaningful during ROWSCAN; the out-of-range select
   // seen in other states is never consumed.
   assign w_row_idx = r_idx[7:0];
   assign w_row     = image[w_row_idx];

   for (genvar g = 0; g < ROWS; g++) begin : g_col
      assign w_col[g] = image[g][r_idx];
   end

   assign w_rc       = 9'($countones(w_row));
   assign w_cc       = 8'($countones(w_col));
   assign w_row_hit  = (w_rc >= 9'(ROW_THRESH));
   assign w_col_hit  = (w_cc >= 8'(COL_THRESH));
   assign w_row_last = (r_idx == 9'(ROWS-1));
   assign w_col_last = (r_idx == 9'(COLS-1));

   // Next column candidates are needed combinationally so the last column
   // is included in the box loaded on the edge entering DONE.
   always_comb begin
      w_colhit_nxt = r_colhit;
      w_left_nxt   = r_left_c;
      w_right_nxt  = r_right_c;
      if (w_col_hit) begin
         if (!r_colhit) begin
            w_left_nxt = r_idx;
         end
         w_right_nxt  = r_idx;
         w_colhit_nxt = 1'b1;
      end
   end

   always_ff @(posedge pixclk) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (dataready)  w_state_nxt = S_ROWSCAN;
         S_ROWSCAN: if (w_row_last) w_state_nxt = S_COLSCAN;
         S_COLSCAN: if (w_col_last) w_state_nxt = S_DONE;
         S_DONE:                    w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pixclk) begin
      if (RESET) begin
         r_idx     <= '0;
         r_rowhit  <= 1'b0;
         r_colhit  <= 1'b0;
         r_top_c   <= '0;
         r_bot_c   <= '0;
         r_left_c  <= '0;
         r_right_c <= '0;
         r_found   <= 1'b0;
         r_top     <= '0;
         r_bottom  <= '0;
         r_left    <= '0;
         r_right   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (dataready) begin
                  r_idx    <= '0;
                  r_rowhit <= 1'b0;
                  r_colhit <= 1'b0;
               end
            end
            S_ROWSCAN: begin
               if (w_row_hit) begin
                  if (!r_rowhit) begin
                     r_top_c <= w_row_idx;
                  end
                  r_bot_c  <= w_row_idx;
                  r_rowhit <= 1'b1;
               end
               r_idx <= w_row_last ? 9'd0 : r_idx + 9'd1;
            end
            S_COLSCAN: begin
               r_colhit  <= w_colhit_nxt;
               r_left_c  <= w_left_nxt;
               r_right_c <= w_right_nxt;
               if (w_col_last) begin
                  r_found <= r_rowhit & w_colhit_nxt;
                  if (r_rowhit & w_colhit_nxt) begin
                     r_top    <= r_top_c;
                     r_bottom <= r_bot_c;
                     r_left   <= w_left_nxt;
                     r_right  <= w_right_nxt;
                  end else begin
                     r_top    <= '0;
                     r_bottom <= '0;
                     r_left   <= '0;
                     r_right  <= '0;
                  end
               end else begin
                  r_idx <= r_idx + 9'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign found  = r_found;
   assign top    = r_top;
   assign bottom = r_bottom;
   assign left   = r_left;
   assign right  = r_right;

endmodule
`default_nettype wire

// File: tb/tb_face_box_locator.sv
`default_nettype none
// ============================================================================
// Module   : tb_face_box_locator
// Function : Directed and randomized image scans of face_box_locator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_face_box_locator;

   localparam int ROWS       = 150;
   localparam int COLS       = 300;
   localparam int ROW_THRESH = 20;
   localparam int COL_THRESH = 10;
   localparam int LATENCY    = ROWS + COLS;

   logic                      pixclk    = 1'b0;
   logic                      RESET     = 1'b1;
   logic                      dataready = 1'b0;
   logic [0:ROWS-1][0:COLS-1] img;
   logic                      busy;
   logic                      done;
   logic                      found;
   logic [7:0]                top;
   logic [7:0]                bottom;
   logic [8:0]                left;
   logic [8:0]                right;

   int total = 0;
   int bad   = 0;

   int e_found, e_top, e_bot, e_left, e_right;

   always #5 pixclk = ~pixclk;

   face_box_locator #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .ROW_THRESH(ROW_THRESH),
      .COL_THRESH(COL_THRESH)
   ) dut (
      .pixclk   (pixclk),
      .RESET    (RESET),
      .dataready(dataready),
      .image    (img),
      .busy     (busy),
      .done     (done),
      .found    (found),
      .top      (top),
      .bottom   (bottom),
      .left     (left),
      .right    (right)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_img();
      img = '0;
   endtask

   task automatic fill_rect(input int r0, input int r1, input int c0, input int c1);
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++)
            img[r][c] = 1'b1;
   endtask

   // Reference: count every row and column directly, keep first/last hits.
   task automatic model();
      int rmin, rmax, cmin, cmax, cnt;
      rmin = -1; rmax = -1; cmin = -1; cmax = -1;
      for (int r = 0; r < ROWS; r++) begin
         cnt = 0;
         for (int c = 0; c < COLS; c++) cnt += int'(img[r][c]);
         if (cnt >= ROW_THRESH) begin
            if (rmin < 0) rmin = r;
            rmax = r;
         end
      end
      for (int c = 0; c < COLS; c++) begin
         cnt = 0;
         for (int r = 0; r < ROWS; r++) cnt += int'(img[r][c]);
         if (cnt >= COL_THRESH) begin
            if (cmin < 0) cmin = c;
            cmax = c;
         end
      end
      if (rmin >= 0 && cmin >= 0) begin
         e_found = 1; e_top = rmin; e_bot = rmax; e_left = cmin; e_right = cmax;
      end else begin
         e_found = 0; e_top = 0; e_bot = 0; e_left = 0; e_right = 0;
      end
   endtask

   task automatic check_box(input string tag);
      check({tag, ":found"},  32'(found),  32'(e_found));
      check({tag, ":top"},    32'(top),    32'(e_top));
      check({tag, ":bottom"}, 32'(bottom), 32'(e_bot));
      check({tag, ":left"},   32'(left),   32'(e_left));
      check({tag, ":right"},  32'(right),  32'(e_right));
   endtask

   // rst_at > 0 aborts the scan with RESET applied on that edge after dataready.
   task automatic run_scan(input string tag, input bit extra, input int rst_at);
      int  n;
      bit  seen;
      model();
      @(posedge pixclk); #1 dataready = 1'b1;
      @(posedge pixclk); #1 dataready = 1'b0;
      check({tag, ":busy_start"}, 32'(busy), 32'd1);
      check({tag, ":done_start"}, 32'(done), 32'd0);
      if (rst_at > 0) begin
         repeat (rst_at - 1) @(posedge pixclk);
         #1 RESET = 1'b1;
         @(posedge pixclk); #1 RESET = 1'b0;
         check({tag, ":rst_busy"}, 32'(busy), 32'd0);
         check({tag, ":rst_done"}, 32'(done), 32'd0);
         e_found = 0; e_top = 0; e_bot = 0; e_left = 0; e_right = 0;
         check_box({tag, ":rst"});
         seen = 1'b0;
         for (int i = 0; i < 500; i++) begin
            @(posedge pixclk); #1;
            if (done || busy) seen = 1'b1;
         end
         check({tag, ":no_done_after_rst"}, 32'(seen), 32'd0);
         return;
      end
      n    = 0;
      seen = 1'b0;
      while (!seen && n < LATENCY + 100) begin
         @(posedge pixclk); #1;
         n++;
         dataready = 1'b0;
         if (done) begin
            seen = 1'b1;
         end else if (extra && (n == 50 || n == 300)) begin
            dataready = 1'b1;
         end
      end
      check({tag, ":latency"}, 32'(n), 32'(LATENCY));
      check_box(tag);
      @(posedge pixclk); #1;
      check({tag, ":done_pulse"}, 32'(done), 32'd0);
      check({tag, ":busy_end"},   32'(busy), 32'd0);
      repeat (3) @(posedge pixclk);
   endtask

   initial begin
      int r0, h, c0, w, nrect, npix;
      clear_img();
      RESET = 1'b1;
      repeat (3) @(posedge pixclk);
      #1;
      check("reset:busy",   32'(busy),   32'd0);
      check("reset:done",   32'(done),   32'd0);
      check("reset:found",  32'(found),  32'd0);
      check("reset:top",    32'(top),    32'd0);
      check("reset:bottom", 32'(bottom), 32'd0);
      check("reset:left",   32'(left),   32'd0);
      check("reset:right",  32'(right),  32'd0);
      RESET = 1'b0;
      repeat (2) @(posedge pixclk);

      clear_img();
      run_scan("zero", 1'b0, 0);

      clear_img(); fill_rect(40, 89, 100, 199);
      run_scan("rect", 1'b0, 0);

      clear_img(); fill_rect(0, 9, 0, 19);
      run_scan("thr_hit", 1'b0, 0);

      clear_img(); fill_rect(0, 9, 0, 18);
      run_scan("thr_miss", 1'b0, 0);

      img = '1;
      run_scan("full", 1'b0, 0);

      clear_img(); fill_rect(40, 89, 100, 199);
      run_scan("extra_dr", 1'b1, 0);

      clear_img(); fill_rect(5, 20, 30, 60);
      run_scan("mid_rst", 1'b0, 200);

      clear_img(); fill_rect(40, 89, 100, 199);
      run_scan("after_rst", 1'b0, 0);

      for (int t = 0; t < 8; t++) begin
         clear_img();
         nrect = $urandom_range(0, 2);
         for (int k = 0; k < nrect; k++) begin
            r0 = $urandom_range(0, ROWS - 1);
            h  = $urandom_range(1, 40);
            c0 = $urandom_range(0, COLS - 1);
            w  = $urandom_range(1, 60);
            fill_rect(r0, (r0 + h > ROWS - 1) ? ROWS - 1 : r0 + h,
                      c0, (c0 + w > COLS - 1) ? COLS - 1 : c0 + w);
         end
         npix = $urandom_range(0, 400);
         for (int k = 0; k < npix; k++)
            img[$urandom_range(0, ROWS - 1)][$urandom_range(0, COLS - 1)] = 1'b1;
         run_scan($sformatf("rand%0d", t), 1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/face_box_locator.md
Name: face_box_locator

Overview:
- Downstream consumer of the binary frame capture stage.
- On that stage's dataready pulse, scans the captured 150x300 black/white image and finds the bounding box of the bright region.
- Two passes: per-row popcount, then per-column popcount.
- Outputs the box (top/bottom/left/right) with found/done for the face-detect logic; busy feeds back as the capture stage's hold-off (cansend = ~busy).

Parameters:
- ROWS, 150, image rows (row index 0..ROWS-1)
- COLS, 300, image columns (col index 0..COLS-1)
- ROW_THRESH, 20, min count of 1-pixels for a row to count as a hit
- COL_THRESH, 10, min count of 1-pixels for a column to count as a hit

Ports:
- pixclk  in  1  pixel clock; all state on posedge
- RESET  in  1  synchronous, active-high reset
- dataready  in  1  one-cycle pulse: image is complete and stable
- image  in  [0:ROWS-1][0:COLS-1]  packed bit image, image[row][col], 1 = bright
- busy  out  1  high in ROWSCAN, COLSCAN, DONE
- done  out  1  one-cycle pulse; box outputs valid from this cycle
- found  out  1  1 = at least one hit row AND at least one hit column
- top  out  8  first hit row
- bottom  out  8  last hit row
- left  out  9  first hit column
- right  out  9  last hit column

Behaviour:
- Reset: state IDLE; busy=0, done=0, found=0, top=bottom=left=right=0; scan index and hit flags cleared.
- RESET mid-scan aborts immediately. Outputs return to 0 and nothing is retained.
- States: IDLE, ROWSCAN, COLSCAN, DONE. busy decodes from registered state.
- IDLE:
  - done=0.
  - When dataready=1: go to ROWSCAN, idx=0, clear rowhit/colhit.
  - Box outputs hold their last values.
- ROWSCAN:
  - Each cycle rc = popcount(image[idx]), 9-bit, max 300.
  - If rc >= ROW_THRESH: set top=idx only if rowhit=0; always set bottom=idx; set rowhit=1.
  - At idx=ROWS-1: go to COLSCAN with idx=0. Otherwise idx++.
- COLSCAN:
  - Each cycle cc = popcount(image[0..ROWS-1][idx]), 8-bit, max 150.
  - Same first/last rule into left/right and colhit.
  - At idx=COLS-1: go to DONE.
- Scan candidates are internal registers. Outputs load only on the edge entering DONE:
  - found = rowhit & colhit.
  - If found: outputs take the candidate values.
  - Else: top/bottom/left/right = 0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Comparisons are >= (equal counts as hit). A single hit row or column gives top=bottom or left=right.
- Latency: dataready sampled at edge k:
  - rows processed at edges k+1..k+150;
  - columns at edges k+151..k+450;
  - done/outputs registered at edge k+450;
  - done deasserts at edge k+451.
- dataready while busy=1 is ignored; no queueing.
- The image must stay stable while busy=1. Guaranteed by the capture stage being held off via cansend = ~busy.
- Index counter is 9 bits. No wrap: the terminal compare precedes the increment.

Test Plan:
- All-zero image, dataready pulse -> busy=1 next cycle; done exactly 450 cycles after the dataready edge; found=0, all box outputs 0; busy=0 the cycle after done.
- Ones at rows 40..89, cols 100..199 (row count 100, col count 50) -> found=1, top=40, bottom=89, left=100, right=199.
- Threshold hit: ones at rows 0..9, cols 0..19 (row count 20, col count 10) -> found=1, top=0, bottom=9, left=0, right=19.
- Threshold miss: ones at rows 0..9, cols 0..18 (row count 19) -> found=0, outputs 0.
- Full-ones image -> top=0, bottom=149, left=0, right=299.
- Extra dataready pulses at cycles 50 and 300 of a scan -> ignored; done still at 450.
- RESET at cycle 200 of a scan -> next cycle busy=0, found=0, outputs 0, no done pulse.
- New dataready after that reset -> full 450-cycle scan with correct box.
